// File: rtl/rx_align_pkg.sv
// Shared types and constants for the HSST lane comma-alignment controller.
// Latency: n/a (declarations only).
// Backpressure: none.
package rx_align_pkg;

   localparam logic [7:0] K28_5  = 8'hBC;
   localparam int         LANES  = 4;
   localparam int         LANE_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      HUNT,
      VERIFY,
      LOCKED,
      RST
   } align_state_t;

   function automatic logic [2:0] hit_count(input logic [LANES-1:0] hits);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + {2'b00, hits[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/rx_comma_detect.sv
// Per-byte K28.5 comma detector: flags a single comma, multiple commas, and the lane index.
// Latency: 1 cycle (registered outputs).
// Backpressure: none; evaluates every received word.
module rx_comma_detect
   import rx_align_pkg::*;
(
   input  logic              rx_clk,
   input  logic              rst_n,
   input  logic [31:0]       rxd,
   input  logic [3:0]        rxk,
   output logic              comma_ok,
   output logic              comma_multi,
   output logic [LANE_W-1:0] comma_pos
);

   logic [LANES-1:0]  hit;
   logic [2:0]        nhit;
   logic [LANE_W-1:0] pos;

   always_comb begin
      hit = '0;
      pos = '0;
      for (int i = 0; i < LANES; i++) begin
         hit[i] = rxk[i] && (rxd[8*i +: 8] == K28_5);
         if (hit[i]) begin
            pos = LANE_W'(i);
         end
      end
      nhit = hit_count(hit);
   end

   always_ff @(posedge rx_clk) begin
      if (!rst_n) begin
         comma_ok    <= 1'b0;
         comma_multi <= 1'b0;
         comma_pos   <= '0;
      end else begin
         comma_ok    <= (nhit == 3'd1);
         comma_multi <= (nhit > 3'd1);
         comma_pos   <= pos;
      end
   end

endmodule

// File: rtl/rx_comma_lock_ctrl.sv
// HSST lane comma hunt/verify/lock controller with lane-reset request; RX_ALIGN_ERR_CNT_EN adds err_cnt.
// Latency: comma detect 1 cycle, state and outputs follow 1 cycle later.
// Backpressure: none; one word is consumed per rx_clk.
module rx_comma_lock_ctrl
   import rx_align_pkg::*;
#(
   parameter int COMMA_PERIOD = 16,
   parameter int LOCK_CNT     = 3,
   parameter int UNLOCK_CNT   = 4,
   parameter int TIMEOUT      = 1024,
   parameter int RST_LEN      = 8
)(
   input  logic        rx_clk,
   input  logic        rst_n,
   input  logic        hsst_rx_ready,
   input  logic [31:0] hsst_rxd,
   input  logic [3:0]  hsst_rxk,
   output logic [1:0]  shift_sel,
   output logic        shift_vld,
   output logic        link_up,
   output logic        lane_rst_req,
   output logic [15:0] err_cnt,
   input  logic        err_clr
);

   localparam int PCNT_W = $clog2(COMMA_PERIOD);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
   localparam int RCNT_W = $clog2(RST_LEN + 1);

   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(COMMA_PERIOD - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
   localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(UNLOCK_CNT);
   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_LEN - 1);

   logic              det_ok;
   logic              det_multi;
   logic [LANE_W-1:0] det_pos;

   align_state_t      state, state_nxt;
   logic [PCNT_W-1:0] pcnt, pcnt_nxt, pcnt_adv;
   logic [TMO_W-1:0]  tmo, tmo_nxt;
   logic [GOOD_W-1:0] good, good_nxt, good_inc;
   logic [MISS_W-1:0] miss, miss_nxt, miss_inc;
   logic [RCNT_W-1:0] rcnt, rcnt_nxt;
   logic [LANE_W-1:0] cand_pos, cand_nxt;
   logic              slot, good_comma, any_comma, tmo_hit;
   logic              err_inc;

   rx_comma_detect u_detect (
      .rx_clk      (rx_clk),
      .rst_n       (rst_n),
      .rxd         (hsst_rxd),
      .rxk         (hsst_rxk),
      .comma_ok    (det_ok),
      .comma_multi (det_multi),
      .comma_pos   (det_pos)
   );

   always_comb begin
      state_nxt  = state;
      pcnt_nxt   = pcnt;
      tmo_nxt    = tmo;
      good_nxt   = good;
      miss_nxt   = miss;
      rcnt_nxt   = '0;
      cand_nxt   = cand_pos;
      err_inc    = 1'b0;
      slot       = (pcnt == PCNT_LAST);
      pcnt_adv   = slot ? '0 : pcnt + 1'b1;
      good_inc   = good + 1'b1;
      miss_inc   = miss + 1'b1;
      good_comma = det_ok && (det_pos == cand_pos);
      any_comma  = det_ok || det_multi;
      tmo_hit    = (tmo == TMO_LAST);

      case (state)
         IDLE: begin
            tmo_nxt = '0;
            if (hsst_rx_ready) begin
               state_nxt = HUNT;
            end
         end
         HUNT: begin
            if (!hsst_rx_ready) begin
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               state_nxt = RST;
            end else begin
               tmo_nxt = tmo + 1'b1;
               if (det_ok) begin
                  cand_nxt  = det_pos;
                  pcnt_nxt  = '0;
                  good_nxt  = '0;
                  state_nxt = VERIFY;
               end
            end
         end
         VERIFY: begin
            // timeout is checked before the slot, so it wins over a completing lock
            if (!hsst_rx_ready) begin
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               state_nxt = RST;
            end else begin
               tmo_nxt  = tmo + 1'b1;
               pcnt_nxt = pcnt_adv;
               if (slot && good_comma) begin
                  good_nxt = good_inc;
                  if (good_inc == GOOD_LOCK) begin
                     miss_nxt  = '0;
                     state_nxt = LOCKED;
                  end
               end else if (slot || any_comma) begin
                  err_inc   = 1'b1;
                  state_nxt = HUNT;
               end
            end
         end
         LOCKED: begin
            tmo_nxt = '0;
            if (!hsst_rx_ready) begin
               state_nxt = IDLE;
            end else begin
               // period keeps free-running; early commas never resync it
               pcnt_nxt = pcnt_adv;
               if (slot && good_comma) begin
                  miss_nxt = '0;
               end else if (slot || any_comma) begin
                  err_inc  = 1'b1;
                  miss_nxt = miss_inc;
                  if (miss_inc == MISS_DROP) begin
                     state_nxt = HUNT;
                  end
               end
            end
         end
         RST: begin
            if (rcnt == RCNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               rcnt_nxt = rcnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge rx_clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         pcnt         <= '0;
         tmo          <= '0;
         good         <= '0;
         miss         <= '0;
         rcnt         <= '0;
         cand_pos     <= '0;
         shift_sel    <= '0;
         shift_vld    <= 1'b0;
         link_up      <= 1'b0;
         lane_rst_req <= 1'b0;
      end else begin
         state        <= state_nxt;
         pcnt         <= pcnt_nxt;
         tmo          <= tmo_nxt;
         good         <= good_nxt;
         miss         <= miss_nxt;
         rcnt         <= rcnt_nxt;
         cand_pos     <= cand_nxt;
         shift_vld    <= (state_nxt == LOCKED);
         link_up      <= (state_nxt == LOCKED);
         lane_rst_req <= (state_nxt == RST);
         if ((state_nxt == LOCKED) && (state != LOCKED)) begin
            shift_sel <= cand_pos;
         end
      end
   end

`ifdef RX_ALIGN_ERR_CNT_EN
   logic [15:0] err_q;

   always_ff @(posedge rx_clk) begin
      if (!rst_n) begin
         err_q <= '0;
      end else if (err_clr) begin
         err_q <= '0;
      end else if (err_inc && (err_q != 16'hFFFF)) begin
         err_q <= err_q + 16'd1;
      end
   end

   assign err_cnt = err_q;
`else
   logic unused_err;

   assign unused_err = err_inc ^ err_clr;
   assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_rx_comma_lock_ctrl.sv
// Bench for rx_comma_lock_ctrl: scenario table, timeout/reset-pulse sequence, random traffic vs reference model.
module tb_rx_comma_lock_ctrl;

   localparam int P  = 16;
   localparam int LK = 3;
   localparam int UL = 4;
   localparam int TO = 1024;
   localparam int RL = 8;
   localparam int C_NONE  = -1;
   localparam int C_MULTI = 4;
`ifdef RX_ALIGN_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        rx_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsst_rx_ready = 1'b0;
   logic [31:0] hsst_rxd = '0;
   logic [3:0]  hsst_rxk = '0;
   logic        err_clr = 1'b0;
   logic [1:0]  shift_sel;
   logic        shift_vld;
   logic        link_up;
   logic        lane_rst_req;
   logic [15:0] err_cnt;

   int total = 0;
   int bad   = 0;

   always #5 rx_clk = ~rx_clk;

   rx_comma_lock_ctrl #(
      .COMMA_PERIOD (P),
      .LOCK_CNT     (LK),
      .UNLOCK_CNT   (UL),
      .TIMEOUT      (TO),
      .RST_LEN      (RL)
   ) dut (
      .rx_clk        (rx_clk),
      .rst_n         (rst_n),
      .hsst_rx_ready (hsst_rx_ready),
      .hsst_rxd      (hsst_rxd),
      .hsst_rxk      (hsst_rxk),
      .shift_sel     (shift_sel),
      .shift_vld     (shift_vld),
      .link_up       (link_up),
      .lane_rst_req  (lane_rst_req),
      .err_cnt       (err_cnt),
      .err_clr       (err_clr)
   );

   // Reference model: time-stamped events (edge numbers) instead of counters.
   typedef enum int {M_IDLE, M_HUNT, M_VERIFY, M_LOCKED, M_RST} mmode_t;
   mmode_t mm = M_IDLE;
   int now = 0, anchor = 0, hunt_t = 0, rst_t = 0;
   int goods = 0, misses = 0, m_cand = 0, m_sel = 0, m_err = 0;
   int prev_nhit = 0, prev_pos = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void make_word(input int code, output logic [31:0] d, output logic [3:0] k);
      logic [1:0] ln;
      d  = $urandom;
      k  = 4'h0;
      ln = code[1:0];
      if (code >= 0 && code < 4) begin
         d[{ln, 3'b000} +: 8] = 8'hBC;
         k[ln] = 1'b1;
      end else if (code == C_MULTI) begin
         d[7:0]   = 8'hBC;
         d[31:24] = 8'hBC;
         k        = 4'b1001;
      end
   endfunction

   task automatic model_step(input bit rdy, input bit clr);
      bit ok, anyc, inc, slot;
      now++;
      ok   = (prev_nhit == 1);
      anyc = (prev_nhit >= 1);
      inc  = 1'b0;
      if (mm == M_RST) begin
         if (now - rst_t == RL) mm = M_IDLE;
      end else if (!rdy) begin
         mm = M_IDLE;
      end else begin
         case (mm)
            M_IDLE: begin mm = M_HUNT; hunt_t = now; end
            M_HUNT: begin
               if (now - hunt_t == TO) begin mm = M_RST; rst_t = now; end
               else if (ok) begin mm = M_VERIFY; anchor = now; m_cand = prev_pos; goods = 0; end
            end
            M_VERIFY: begin
               if (now - hunt_t == TO) begin mm = M_RST; rst_t = now; end
               else if (now - anchor == P) begin
                  if (ok && prev_pos == m_cand) begin
                     goods++;
                     anchor = now;
                     if (goods == LK) begin mm = M_LOCKED; misses = 0; m_sel = m_cand; end
                  end else begin
                     inc = 1'b1; mm = M_HUNT;
                  end
               end else if (anyc) begin
                  inc = 1'b1; mm = M_HUNT;
               end
            end
            M_LOCKED: begin
               slot = ((now - anchor) % P == 0);
               if (slot && ok && prev_pos == m_cand) misses = 0;
               else if (slot || anyc) begin
                  inc = 1'b1;
                  misses++;
                  if (misses == UL) begin mm = M_HUNT; hunt_t = now; end
               end
            end
            default: mm = M_IDLE;
         endcase
      end
      if (clr) m_err = 0;
      else if (inc && m_err < 65535) m_err++;
   endtask

   task automatic tick(input bit rdy, input logic [31:0] d, input logic [3:0] k, input bit clr);
      int nh, pp;
      hsst_rx_ready = rdy;
      hsst_rxd      = d;
      hsst_rxk      = k;
      err_clr       = clr;
      @(posedge rx_clk);
      model_step(rdy, clr);
      nh = 0;
      pp = 0;
      for (int i = 0; i < 4; i++) begin
         if (k[i] && d[i*8 +: 8] == 8'hBC) begin nh++; pp = i; end
      end
      prev_nhit = nh;
      prev_pos  = pp;
      #1;
      chk("link_up", int'(link_up), int'(mm == M_LOCKED));
      chk("shift_vld", int'(shift_vld), int'(mm == M_LOCKED));
      chk("shift_sel", int'(shift_sel), m_sel);
      chk("lane_rst_req", int'(lane_rst_req), int'(mm == M_RST));
      chk("err_cnt", int'(err_cnt), ERR_EN ? m_err : 0);
   endtask

   task automatic run_block(input int code, input bit rdy0, input bit clr0);
      logic [31:0] d;
      logic [3:0]  k;
      make_word(code, d, k);
      tick(rdy0, d, k, clr0);
      for (int i = 1; i < P; i++) begin
         make_word(C_NONE, d, k);
         tick(1'b1, d, k, 1'b0);
      end
   endtask

   typedef struct {
      int code;
      bit rdy0;
      bit clr0;
      bit e_link;
      bit e_vld;
      int e_sel;
      int e_err;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [31:0] d;
      logic [3:0]  k;
      int first_hi, hi_cnt, ph, lane, code;
      bit rdy;

      // one comma per 16-word block; expectations taken at the end of each block
      tbl.push_back(vec_t'{2,       1, 0, 0, 0, 0, 0});
      tbl.push_back(vec_t'{2,       1, 0, 0, 0, 0, 0});
      tbl.push_back(vec_t'{2,       1, 0, 0, 0, 0, 0});
      tbl.push_back(vec_t'{2,       1, 0, 1, 1, 2, 0});
      tbl.push_back(vec_t'{C_NONE,  1, 0, 1, 1, 2, 1});
      tbl.push_back(vec_t'{C_NONE,  1, 0, 1, 1, 2, 2});
      tbl.push_back(vec_t'{C_NONE,  1, 0, 1, 1, 2, 3});
      tbl.push_back(vec_t'{2,       1, 0, 1, 1, 2, 3});
      tbl.push_back(vec_t'{C_NONE,  1, 0, 1, 1, 2, 4});
      tbl.push_back(vec_t'{C_NONE,  1, 0, 1, 1, 2, 5});
      tbl.push_back(vec_t'{C_NONE,  1, 0, 1, 1, 2, 6});
      tbl.push_back(vec_t'{C_NONE,  1, 0, 0, 0, 2, 7});
      tbl.push_back(vec_t'{2,       1, 0, 0, 0, 2, 7});
      tbl.push_back(vec_t'{2,       1, 0, 0, 0, 2, 7});
      tbl.push_back(vec_t'{1,       1, 0, 0, 0, 2, 8});
      tbl.push_back(vec_t'{2,       1, 0, 0, 0, 2, 8});
      tbl.push_back(vec_t'{2,       1, 0, 0, 0, 2, 8});
      tbl.push_back(vec_t'{2,       1, 0, 0, 0, 2, 8});
      tbl.push_back(vec_t'{2,       1, 0, 1, 1, 2, 8});
      tbl.push_back(vec_t'{C_MULTI, 1, 0, 1, 1, 2, 9});
      tbl.push_back(vec_t'{1,       1, 0, 1, 1, 2, 10});
      tbl.push_back(vec_t'{2,       1, 0, 1, 1, 2, 10});
      tbl.push_back(vec_t'{2,       1, 1, 1, 1, 2, 0});
      tbl.push_back(vec_t'{C_NONE,  0, 0, 0, 0, 2, 0});
      tbl.push_back(vec_t'{3,       1, 0, 0, 0, 2, 0});
      tbl.push_back(vec_t'{3,       1, 0, 0, 0, 2, 0});
      tbl.push_back(vec_t'{3,       1, 0, 0, 0, 2, 0});
      tbl.push_back(vec_t'{3,       1, 0, 1, 1, 3, 0});

      repeat (3) @(posedge rx_clk);
      #1;
      chk("rst_link_up", int'(link_up), 0);
      chk("rst_shift_vld", int'(shift_vld), 0);
      chk("rst_shift_sel", int'(shift_sel), 0);
      chk("rst_lane_rst_req", int'(lane_rst_req), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_block(tbl[i].code, tbl[i].rdy0, tbl[i].clr0);
         chk($sformatf("tbl%0d_link_up", i), int'(link_up), int'(tbl[i].e_link));
         chk($sformatf("tbl%0d_shift_vld", i), int'(shift_vld), int'(tbl[i].e_vld));
         chk($sformatf("tbl%0d_shift_sel", i), int'(shift_sel), tbl[i].e_sel);
         chk($sformatf("tbl%0d_err_cnt", i), int'(err_cnt), ERR_EN ? tbl[i].e_err : 0);
      end

      // timeout: ready held, no commas; ready drops mid-pulse and must not cut it short
      make_word(C_NONE, d, k);
      tick(1'b0, d, k, 1'b0);
      first_hi = 0;
      hi_cnt   = 0;
      rdy      = 1'b1;
      for (int n = 1; n <= 1100; n++) begin
         make_word(C_NONE, d, k);
         tick(rdy, d, k, 1'b0);
         if (lane_rst_req) begin
            if (first_hi == 0) first_hi = n;
            hi_cnt++;
            if (hi_cnt == 3) rdy = 1'b0;
         end
      end
      chk("timeout_first_req_cycle", first_hi, TO + 1);
      chk("rst_pulse_len", hi_cnt, RL);
      chk("after_pulse_link_up", int'(link_up), 0);

      ph   = 0;
      lane = 2;
      for (int n = 0; n < 8000; n++) begin
         if (n % 1500 == 0) lane = $urandom_range(0, 3);
         if ($urandom_range(0, 499) == 0) ph = 0;
         if (ph == 0) code = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) - 1 : lane;
         else code = ($urandom_range(0, 199) == 0) ? $urandom_range(0, 4) : C_NONE;
         make_word(code, d, k);
         if (code == C_NONE && $urandom_range(0, 49) == 0) k = 4'($urandom_range(0, 15));
         tick($urandom_range(0, 999) >= 3, d, k, $urandom_range(0, 499) == 0);
         ph = (ph == P - 1) ? 0 : ph + 1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
